// File: rtl/i2c_regbank.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_regbank
//  Description : Byte-level register bank behind an I2C slave front end.
//                Pointer byte, then data writes or reads.
//                Optional macro I2C_REGBANK_AUTOINC_EN turns on pointer
//                auto-increment after each data byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_regbank #(
    parameter int PTR_W = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      txn_start_i,
    input  logic                      rw_i,
    input  logic                      stop_i,
    input  logic                      wr_valid_i,
    input  logic [7:0]                wr_data_i,
    input  logic                      rd_req_i,
    output logic [7:0]                rd_data_o,
    output logic                      rd_valid_o,
    output logic                      wr_strobe_o,
    output logic [PTR_W-1:0]          wr_addr_o,
    output logic [PTR_W-1:0]          ptr_o,
    output logic                      err_o,
    output logic [(2**PTR_W)*8-1:0]   regs_o
);

    localparam int NUM_REGS = 2**PTR_W;
    localparam logic [PTR_W-1:0] c_PTR_ONE = PTR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GET_PTR = 2'd1,
        S_WR_DATA = 2'd2,
        S_RD_DATA = 2'd3
    } state_t;

    state_t             r_state;
    logic [7:0]         r_regs [NUM_REGS];
    logic [PTR_W-1:0]   r_ptr;
    logic [7:0]         r_rd_data;
    logic               r_rd_valid;
    logic               r_wr_strobe;
    logic               r_err;
    logic               w_ptr_oob;
    logic [PTR_W-1:0]   w_ptr_next;

    // Any set bit above the pointer field means the master addressed a
    // register that does not exist.
    generate
        if (PTR_W < 8) begin : g_oob_check
            assign w_ptr_oob = |wr_data_i[7:PTR_W];
        end else begin : g_oob_none
            assign w_ptr_oob = 1'b0;
        end
    endgenerate

`ifdef I2C_REGBANK_AUTOINC_EN
    logic [PTR_W-1:0]   r_wr_addr;
    assign w_ptr_next = r_ptr + c_PTR_ONE;
    assign wr_addr_o  = r_wr_addr;
`else
    assign w_ptr_next = r_ptr;
    assign wr_addr_o  = r_ptr;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_regs      <= '{default: '0};
            r_ptr       <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_err       <= 1'b0;
`ifdef I2C_REGBANK_AUTOINC_EN
            r_wr_addr   <= '0;
`endif
        end else begin
            r_rd_valid  <= 1'b0;
            r_wr_strobe <= 1'b0;
            // A new transaction drops any byte arriving in the same cycle.
            if (txn_start_i) begin
                if (rw_i) begin
                    r_state <= S_RD_DATA;
                end else begin
                    r_state <= S_GET_PTR;
                    r_err   <= 1'b0;
                end
            end else begin
                case (r_state)
                    S_GET_PTR: begin
                        if (wr_valid_i) begin
                            r_ptr   <= wr_data_i[PTR_W-1:0];
                            if (w_ptr_oob)
                                r_err <= 1'b1;
                            r_state <= S_WR_DATA;
                        end
                    end
                    S_WR_DATA: begin
                        if (wr_valid_i) begin
                            r_regs[r_ptr] <= wr_data_i;
                            r_wr_strobe   <= 1'b1;
`ifdef I2C_REGBANK_AUTOINC_EN
                            r_wr_addr     <= r_ptr;
`endif
                            r_ptr         <= w_ptr_next;
                        end
                    end
                    S_RD_DATA: begin
                        if (rd_req_i) begin
                            r_rd_data  <= r_regs[r_ptr];
                            r_rd_valid <= 1'b1;
                            r_ptr      <= w_ptr_next;
                        end
                    end
                    default: ;
                endcase
                // STOP lands after the byte above has been handled.
                if (stop_i)
                    r_state <= S_IDLE;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
            assign regs_o[8*gi +: 8] = r_regs[gi];
        end
    endgenerate

    assign rd_data_o   = r_rd_data;
    assign rd_valid_o  = r_rd_valid;
    assign wr_strobe_o = r_wr_strobe;
    assign ptr_o       = r_ptr;
    assign err_o       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_i2c_regbank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_regbank
//  Description : Self-checking bench for i2c_regbank: directed vector table,
//                hand sequences and randomized traffic against a model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_regbank;

    localparam int PTR_W = 3;
    localparam int N     = 8;
`ifdef I2C_REGBANK_AUTOINC_EN
    localparam bit AI = 1'b1;
`else
    localparam bit AI = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset, txn_start_i, rw_i, stop_i, wr_valid_i, rd_req_i;
    logic [7:0]         wr_data_i;
    logic [7:0]         rd_data_o;
    logic               rd_valid_o, wr_strobe_o, err_o;
    logic [PTR_W-1:0]   wr_addr_o, ptr_o;
    logic [8*N-1:0]     regs_o;

    always #5 clk = ~clk;

    i2c_regbank #(.PTR_W(PTR_W)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .txn_start_i (txn_start_i),
        .rw_i        (rw_i),
        .stop_i      (stop_i),
        .wr_valid_i  (wr_valid_i),
        .wr_data_i   (wr_data_i),
        .rd_req_i    (rd_req_i),
        .rd_data_o   (rd_data_o),
        .rd_valid_o  (rd_valid_o),
        .wr_strobe_o (wr_strobe_o),
        .wr_addr_o   (wr_addr_o),
        .ptr_o       (ptr_o),
        .err_o       (err_o),
        .regs_o      (regs_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: transaction phase 0 idle, 1 expecting pointer,
    // 2 writing data, 3 reading data.
    logic [7:0] m_mem [N];
    int         m_ptr, m_wa, m_phase;
    bit         m_err, m_rv, m_ws;
    logic [7:0] m_rd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit txn, input bit rw, input bit stp,
                              input bit wv, input logic [7:0] wd, input bit rq);
        m_rv = 1'b0;
        m_ws = 1'b0;
        if (rst) begin
            foreach (m_mem[i]) m_mem[i] = 8'h00;
            m_ptr = 0; m_err = 1'b0; m_rd = 8'h00; m_wa = 0; m_phase = 0;
        end else if (txn) begin
            m_phase = rw ? 3 : 1;
            if (!rw) m_err = 1'b0;
        end else begin
            if (m_phase == 1 && wv) begin
                m_ptr = int'(wd) % N;
                if (int'(wd) >= N) m_err = 1'b1;
                m_phase = 2;
            end else if (m_phase == 2 && wv) begin
                m_mem[m_ptr] = wd;
                m_ws = 1'b1;
                m_wa = m_ptr;
                if (AI) m_ptr = (m_ptr + 1) % N;
            end else if (m_phase == 3 && rq) begin
                m_rd = m_mem[m_ptr];
                m_rv = 1'b1;
                if (AI) m_ptr = (m_ptr + 1) % N;
            end
            if (stp) m_phase = 0;
        end
        if (!AI) m_wa = m_ptr;
    endtask

    task automatic do_cycle(input bit rst, input bit txn, input bit rw, input bit stp,
                            input bit wv, input logic [7:0] wd, input bit rq);
        logic [8*N-1:0] exp_regs;
        reset = rst; txn_start_i = txn; rw_i = rw; stop_i = stp;
        wr_valid_i = wv; wr_data_i = wd; rd_req_i = rq;
        @(posedge clk);
        model_step(rst, txn, rw, stp, wv, wd, rq);
        #1;
        for (int i = 0; i < N; i++) exp_regs[8*i +: 8] = m_mem[i];
        check("ptr_o",       64'(ptr_o),       64'(m_ptr));
        check("err_o",       64'(err_o),       64'(m_err));
        check("rd_valid_o",  64'(rd_valid_o),  64'(m_rv));
        check("rd_data_o",   64'(rd_data_o),   64'(m_rd));
        check("wr_strobe_o", 64'(wr_strobe_o), 64'(m_ws));
        check("wr_addr_o",   64'(wr_addr_o),   64'(m_wa));
        check("regs_o",      64'(regs_o),      64'(exp_regs));
    endtask

    typedef struct {
        bit         txn, rw, stp, wv;
        logic [7:0] wd;
        bit         rq;
        int         e_ptr;
        bit         e_err, e_rv;
        logic [7:0] e_rd;
        bit         e_ws;
        int         e_wa;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input bit txn, input bit rw, input bit stp, input bit wv,
                     input logic [7:0] wd, input bit rq, input int e_ptr, input bit e_err,
                     input bit e_rv, input logic [7:0] e_rd, input bit e_ws, input int e_wa);
        vec_t r;
        r.txn = txn; r.rw = rw; r.stp = stp; r.wv = wv; r.wd = wd; r.rq = rq;
        r.e_ptr = e_ptr; r.e_err = e_err; r.e_rv = e_rv; r.e_rd = e_rd;
        r.e_ws = e_ws; r.e_wa = e_wa;
        tbl.push_back(r);
    endtask

    initial begin
        // Write ptr 2, data A5, 3C
        v(1,0,0,0,8'h00,0, 0,            0,0,8'h00,0,0);
        v(0,0,0,1,8'h02,0, 2,            0,0,8'h00,0,0);
        v(0,0,0,1,8'hA5,0, AI ? 3 : 2,   0,0,8'h00,1,2);
        v(0,0,0,1,8'h3C,0, AI ? 4 : 2,   0,0,8'h00,1,AI ? 3 : 2);
        v(0,0,1,0,8'h00,0, AI ? 4 : 2,   0,0,8'h00,0,0);
        // Write ptr 7 with wrap
        v(1,0,0,0,8'h00,0, AI ? 4 : 2,   0,0,8'h00,0,0);
        v(0,0,0,1,8'h07,0, 7,            0,0,8'h00,0,0);
        v(0,0,0,1,8'h11,0, AI ? 0 : 7,   0,0,8'h00,1,7);
        v(0,0,0,1,8'h22,0, AI ? 1 : 7,   0,0,8'h00,1,AI ? 0 : 7);
        v(0,0,1,0,8'h00,0, AI ? 1 : 7,   0,0,8'h00,0,0);
        // Pointer 1, repeated START read, three requests
        v(1,0,0,0,8'h00,0, AI ? 1 : 7,   0,0,8'h00,0,0);
        v(0,0,0,1,8'h01,0, 1,            0,0,8'h00,0,0);
        v(1,1,0,0,8'h00,0, 1,            0,0,8'h00,0,0);
        v(0,0,0,0,8'h00,1, AI ? 2 : 1,   0,1,8'h00,0,0);
        v(0,0,0,0,8'h00,1, AI ? 3 : 1,   0,1,AI ? 8'hA5 : 8'h00,0,0);
        v(0,0,0,0,8'h00,1, AI ? 4 : 1,   0,1,AI ? 8'h3C : 8'h00,0,0);
        v(0,0,1,0,8'h00,0, AI ? 4 : 1,   0,0,8'h00,0,0);
        // Out-of-range pointer, cleared by next write start
        v(1,0,0,0,8'h00,0, AI ? 4 : 1,   0,0,8'h00,0,0);
        v(0,0,0,1,8'h0A,0, 2,            1,0,8'h00,0,0);
        v(0,0,1,0,8'h00,0, 2,            1,0,8'h00,0,0);
        v(1,0,0,0,8'h00,0, 2,            0,0,8'h00,0,0);
        v(0,0,1,0,8'h00,0, 2,            0,0,8'h00,0,0);
        // STOP together with data byte, then ignored byte in idle
        v(1,0,0,0,8'h00,0, 2,            0,0,8'h00,0,0);
        v(0,0,0,1,8'h05,0, 5,            0,0,8'h00,0,0);
        v(0,0,1,1,8'h77,0, AI ? 6 : 5,   0,0,8'h00,1,5);
        v(0,0,0,1,8'h88,0, AI ? 6 : 5,   0,0,8'h00,0,0);
        v(0,0,0,0,8'h00,1, AI ? 6 : 5,   0,0,8'h00,0,0);

        do_cycle(1,0,0,0,0,8'h00,0);
        do_cycle(1,0,0,0,0,8'h00,0);
        check("rst_ptr",   64'(ptr_o),       64'd0);
        check("rst_err",   64'(err_o),       64'd0);
        check("rst_rdv",   64'(rd_valid_o),  64'd0);
        check("rst_rdd",   64'(rd_data_o),   64'd0);
        check("rst_ws",    64'(wr_strobe_o), 64'd0);
        check("rst_wa",    64'(wr_addr_o),   64'd0);
        check("rst_regs",  64'(regs_o),      64'd0);

        for (int k = 0; k < tbl.size(); k++) begin
            do_cycle(0, tbl[k].txn, tbl[k].rw, tbl[k].stp, tbl[k].wv, tbl[k].wd, tbl[k].rq);
            check($sformatf("vec%0d_ptr", k), 64'(ptr_o),       64'(tbl[k].e_ptr));
            check($sformatf("vec%0d_err", k), 64'(err_o),       64'(tbl[k].e_err));
            check($sformatf("vec%0d_rv",  k), 64'(rd_valid_o),  64'(tbl[k].e_rv));
            check($sformatf("vec%0d_ws",  k), 64'(wr_strobe_o), 64'(tbl[k].e_ws));
            if (tbl[k].e_rv) check($sformatf("vec%0d_rd", k), 64'(rd_data_o), 64'(tbl[k].e_rd));
            if (tbl[k].e_ws) check($sformatf("vec%0d_wa", k), 64'(wr_addr_o), 64'(tbl[k].e_wa));
        end
        check("reg5_after_stop", 64'(regs_o[47:40]), 64'h77);

        // Reads at pointer 3, then reset in the middle of the read
        do_cycle(0,1,0,0,0,8'h00,0);
        do_cycle(0,0,0,0,1,8'h03,0);
        do_cycle(0,0,0,0,1,8'h5A,0);
        do_cycle(0,0,0,1,0,8'h00,0);
        do_cycle(0,1,0,0,0,8'h00,0);
        do_cycle(0,0,0,0,1,8'h03,0);
        do_cycle(0,1,1,0,0,8'h00,0);
        do_cycle(0,0,0,0,0,8'h00,1);
        check("rd3_first", 64'(rd_data_o), 64'h5A);
        do_cycle(0,0,0,0,0,8'h00,1);
`ifdef I2C_REGBANK_AUTOINC_EN
        check("rd4_second", 64'(rd_data_o), 64'(regs_o[39:32]));
        check("ptr_after_2rd", 64'(ptr_o), 64'd5);
`else
        check("rd3_second", 64'(rd_data_o), 64'h5A);
        check("ptr_stays_3", 64'(ptr_o), 64'd3);
`endif
        do_cycle(1,0,0,0,0,8'h00,1);
        check("mid_rst_ptr",  64'(ptr_o),       64'd0);
        check("mid_rst_rdv",  64'(rd_valid_o),  64'd0);
        check("mid_rst_rdd",  64'(rd_data_o),   64'd0);
        check("mid_rst_ws",   64'(wr_strobe_o), 64'd0);
        check("mid_rst_wa",   64'(wr_addr_o),   64'd0);
        check("mid_rst_err",  64'(err_o),       64'd0);
        check("mid_rst_regs", 64'(regs_o),      64'd0);
        do_cycle(0,0,0,0,0,8'h00,1);
        check("rd_after_rst", 64'(rd_valid_o), 64'd0);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            bit r_rst, r_txn, r_rw, r_stp, r_wv, r_rq;
            logic [7:0] r_wd;
            r_rst = ($urandom_range(0, 199) == 0);
            r_txn = ($urandom_range(0, 11) == 0);
            r_rw  = $urandom_range(0, 1) == 1;
            r_stp = ($urandom_range(0, 13) == 0);
            r_wv  = ($urandom_range(0, 2) == 0);
            r_rq  = ($urandom_range(0, 2) == 0);
            r_wd  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                : 8'($urandom_range(0, N - 1));
            do_cycle(r_rst, r_txn, r_rw, r_stp, r_wv, r_wd, r_rq);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_regbank.md
# i2c_regbank

Byte-level register bank behind the I2C slave front end. Once the front end matches the device address, it delivers each received data byte to this block and requests each byte it must transmit. The first byte of a write transaction loads the register pointer. Later write bytes store into registers; read bytes are fetched from them, with pointer auto-increment. Register contents are exported in parallel to the demo logic.

## Interface
Parameters:
- PTR_W, 3: pointer width; NUM_REGS = 2**PTR_W registers, 8 bits each.

Ports (reset reset, synchronous, active-high; clock clk):
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- txn_start_i  input  1  one-cycle pulse: address matched (START or repeated START)
- rw_i  input  1  direction, sampled with txn_start_i; 0 = master writes, 1 = master reads
- stop_i  input  1  one-cycle pulse: STOP detected on bus
- wr_valid_i  input  1  one-cycle pulse: wr_data_i holds a received byte
- wr_data_i  input  8  received byte
- rd_req_i  input  1  one-cycle pulse: front end needs next transmit byte
- rd_data_o  output  8  byte to transmit
- rd_valid_o  output  1  one-cycle pulse: rd_data_o updated
- wr_strobe_o  output  1  one-cycle pulse: a register was written
- wr_addr_o  output  PTR_W  index of register written, valid with wr_strobe_o
- ptr_o  output  PTR_W  current register pointer
- err_o  output  1  sticky: pointer byte out of range
- regs_o  output  NUM_REGS*8  flat register contents, reg i at bits [8i+7:8i]

## Operation
- Reset values: all registers 0x00, ptr_o 0, rd_data_o 0x00, rd_valid_o 0, wr_strobe_o 0, wr_addr_o 0, err_o 0, state IDLE.
- States: IDLE, GET_PTR, WR_DATA, RD_DATA.
- Any state, txn_start_i=1:
  - rw_i=0: go to GET_PTR and clear err_o.
  - rw_i=1: go to RD_DATA; pointer kept, so write-pointer/repeated-START/read sequences work.
- Any state, stop_i=1 without txn_start_i: go to IDLE. Pointer and registers are kept.
- GET_PTR, wr_valid_i:
  - ptr <= wr_data_i[PTR_W-1:0].
  - If wr_data_i[7:PTR_W] != 0, set err_o (pointer still loaded from low bits).
  - Go to WR_DATA.
- WR_DATA, wr_valid_i:
  - reg[ptr] <= wr_data_i.
  - Pulse wr_strobe_o with wr_addr_o = old ptr.
  - ptr <= ptr+1 mod NUM_REGS (wraps NUM_REGS-1 -> 0).
- RD_DATA, rd_req_i: rd_data_o <= reg[ptr], pulse rd_valid_o, ptr <= ptr+1 mod NUM_REGS.
- Ignored events:
  - wr_valid_i in IDLE or RD_DATA.
  - rd_req_i in IDLE, GET_PTR or WR_DATA. rd_valid_o stays 0 and rd_data_o holds.
- Simultaneous events in the same cycle:
  - txn_start_i with stop_i: txn_start_i wins.
  - wr_valid_i or rd_req_i with stop_i: the byte is processed first, then the state goes to IDLE.
  - wr_valid_i or rd_req_i with txn_start_i: the byte is dropped and the new transaction takes effect.
- Reset mid-transaction: everything returns to reset values next cycle; the partial transaction is lost.

## Timing
- Write: wr_valid_i in cycle N -> register, ptr_o, wr_strobe_o and wr_addr_o updated at edge N+1.
- Read: rd_req_i in cycle N -> rd_data_o and rd_valid_o at edge N+1. One-cycle latency, well inside one SCL low phase.
- regs_o is registered and reflects a write one cycle after wr_valid_i.
- Back-to-back wr_valid_i or rd_req_i on consecutive cycles must be supported with no stalls.

## Configuration
- I2C_REGBANK_AUTOINC_EN defined: ptr increments after every data write and read, as described above.
- Not defined: ptr changes only in GET_PTR. Repeated writes and reads hit the same register. wr_addr_o always equals ptr_o.

## Test plan
- Reset, then write txn: ptr 0x02, data 0xA5, 0x3C -> reg2=0xA5, reg3=0x3C, ptr_o=4, two wr_strobe_o pulses with wr_addr_o 2, 3; err_o=0.
- Write ptr 0x07, data 0x11, 0x22 (PTR_W=3) -> reg7=0x11, reg0=0x22 (wrap), ptr_o=1.
- Write ptr 0x01, repeated START rw=1, three rd_req_i -> rd_data_o = reg1, reg2, reg3, each one cycle after its request; ptr_o=4.
- Write ptr 0x0A -> err_o=1, ptr_o=2. The next write txn_start_i clears err_o.
- stop_i together with wr_valid_i in WR_DATA (ptr 5, data 0x77) -> reg5=0x77, state IDLE. A following wr_valid_i changes nothing.
- reset asserted mid-read -> all outputs return to reset values. Without I2C_REGBANK_AUTOINC_EN, two reads at ptr 3 both return reg3 and ptr_o stays 3.
